// File: rtl/sdram_master_arbiter.sv
// Two-port Avalon-MM arbiter in front of the SDRAM master: round-robin grant with lock,
// hold limit and outstanding-read tracking so read returns reach the port that issued them.
module sdram_master_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned MAX_HOLD        = 64
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] p0_address,
    input  logic                  p0_read,
    input  logic                  p0_write,
    input  logic [DATA_WIDTH-1:0] p0_writedata,
    input  logic                  p0_lock,
    output logic                  p0_waitrequest,
    output logic [DATA_WIDTH-1:0] p0_readdata,
    output logic                  p0_readdatavalid,

    input  logic [ADDR_WIDTH-1:0] p1_address,
    input  logic                  p1_read,
    input  logic                  p1_write,
    input  logic [DATA_WIDTH-1:0] p1_writedata,
    input  logic                  p1_lock,
    output logic                  p1_waitrequest,
    output logic [DATA_WIDTH-1:0] p1_readdata,
    output logic                  p1_readdatavalid,

    output logic [ADDR_WIDTH-1:0] master_address,
    output logic                  master_read,
    output logic                  master_write,
    output logic [DATA_WIDTH-1:0] master_writedata,
    input  logic                  master_waitrequest,
    input  logic [DATA_WIDTH-1:0] master_readdata,
    input  logic                  master_readdatavalid,

    output logic [1:0]            grant,
    output logic                  err_underflow
);

    localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, DRAIN} state_t;

    state_t              state;
    logic [OUT_W-1:0]    outstanding;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                last_grant;
    logic                owner;

    logic                req0, req1;
    logic                in_grant, sel;
    logic                cur_read, cur_write, cur_lock, cur_req, oth_req;
    logic [ADDR_WIDTH-1:0] cur_address;
    logic [DATA_WIDTH-1:0] cur_writedata;
    logic                full, release_c, issue_ok, cur_wait;
    logic                accept, inc, dec;
    logic [OUT_W-1:0]    out_next;
    logic                arb_valid, arb_port;

    // Owner mux, stall/release decisions and read-return routing.
    always_comb begin
        req0          = p0_read | p0_write;
        req1          = p1_read | p1_write;
        in_grant      = (state == GRANT0) || (state == GRANT1);
        sel           = (state == GRANT1);
        cur_read      = sel ? p1_read      : p0_read;
        cur_write     = sel ? p1_write     : p0_write;
        cur_lock      = sel ? p1_lock      : p0_lock;
        cur_address   = sel ? p1_address   : p0_address;
        cur_writedata = sel ? p1_writedata : p0_writedata;
        cur_req       = sel ? req1 : req0;
        oth_req       = sel ? req0 : req1;

        full      = (outstanding == OUT_W'(MAX_OUTSTANDING));
        release_c = in_grant && !cur_lock &&
                    (!cur_req || ((hold_cnt == HOLD_W'(MAX_HOLD)) && oth_req));
        // A releasing owner issues nothing in its last granted cycle.
        issue_ok  = in_grant && !release_c;

        master_read      = issue_ok && cur_read && !full;
        master_write     = issue_ok && cur_write;
        master_address   = in_grant ? cur_address   : '0;
        master_writedata = in_grant ? cur_writedata : '0;

        cur_wait       = !issue_ok || master_waitrequest || (cur_read && full);
        p0_waitrequest = (state == GRANT0) ? cur_wait : 1'b1;
        p1_waitrequest = (state == GRANT1) ? cur_wait : 1'b1;

        accept = (master_read || master_write) && !master_waitrequest;
        inc    = accept && master_read;
        dec    = master_readdatavalid && (outstanding != '0);

        p0_readdatavalid = dec && !owner;
        p1_readdatavalid = dec && owner;
        p0_readdata      = master_readdata;
        p1_readdata      = master_readdata;

        out_next = outstanding;
        if (inc && !dec) begin
            out_next = outstanding + OUT_W'(1);
        end else if (!inc && dec) begin
            out_next = outstanding - OUT_W'(1);
        end

        arb_valid = req0 || req1;
        arb_port  = (req0 && req1) ? !last_grant : req1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            outstanding   <= '0;
            hold_cnt      <= '0;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            grant         <= 2'b00;
            err_underflow <= 1'b0;
        end else begin
            outstanding <= out_next;
            if (master_readdatavalid && (outstanding == '0)) begin
                err_underflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        state    <= arb_port ? GRANT1 : GRANT0;
                        owner    <= arb_port;
                        grant    <= arb_port ? 2'b10 : 2'b01;
                        hold_cnt <= '0;
                    end
                end
                GRANT0, GRANT1: begin
                    if (release_c) begin
                        last_grant <= sel;
                        hold_cnt   <= '0;
                        grant      <= 2'b00;
                        state      <= (out_next == '0) ? IDLE : DRAIN;
                    end else if (accept && (hold_cnt != HOLD_W'(MAX_HOLD))) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                DRAIN: begin
                    if (out_next == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
